bitserial_logic_seq: RTL

Sequencer that runs a WIDTH-bit bitwise logic operation through a single shared 1-bit two-input AND cell, one bit per clock, LSB first. It derives AND, OR, NAND and NOR from that one AND cell by inverting the gate inputs and/or output (De Morgan). It sits between the register/operand stage and the external 1-bit AND cell, providing a start/busy/done handshake and a completed-result register.

---
 rtl/bitserial_logic_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bitserial_logic_seq.sv
// Bit-serial sequencer: runs a WIDTH-bit AND/OR/NAND/NOR, LSB first, through one
// external 1-bit AND cell, deriving the other operations by De Morgan inversion.
module bitserial_logic_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_r,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       op_q, op_d;
  // Holds the WIDTH-1 bits captured so far; the final bit joins it straight into result.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             r_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // OR/NOR invert the gate inputs; OR/NAND invert the gate output.
  always_comb begin
    gate_a = 1'b0;
    gate_b = 1'b0;
    if (state_q == ST_RUN) begin
      gate_a = a_sh_q[0] ^ op_q[0];
      gate_b = b_sh_q[0] ^ op_q[0];
    end
    r_eff = gate_r ^ (op_q[0] ^ op_q[1]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          a_sh_d            = a_sh_q >> 1;
          b_sh_d            = b_sh_q >> 1;
          acc_d             = acc_q >> 1;
          acc_d[WIDTH-2]    = r_eff;
          cnt_d             = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = {r_eff, acc_q};
            cnt_d    = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule
